// File: rtl/i2c_to_spi_fifo.sv
// i2c_to_spi_fifo: I2C-style byte receiver (no address phase) that buffers bytes
// in a FIFO drained as SPI mode-0 frames, one byte per chip-select assertion.
module i2c_to_spi_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int SPI_CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i2c_scl,
    input  logic i2c_sda,
    output logic i2c_sda_oe,
    output logic spi_sclk,
    output logic spi_mosi,
    output logic spi_cs_n,
    output logic fifo_full,
    output logic fifo_empty,
    output logic overflow
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int RX_CW = $clog2(DATA_WIDTH) + 1;
    localparam int TX_CW = $clog2(DATA_WIDTH) + 1;
    localparam int DIV_W = $clog2(SPI_CLK_DIV) + 1;

    localparam logic [RX_CW-1:0] RX_FULL_CNT = RX_CW'(DATA_WIDTH);
    localparam logic [TX_CW-1:0] TX_LAST_BIT = TX_CW'(DATA_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SPI_CLK_DIV - 1);

    typedef enum logic [1:0] {R_IDLE, R_DATA, R_ACK} rx_state_t;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} tx_state_t;

    logic scl_meta, scl_s, scl_d;
    logic sda_meta, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det;

    rx_state_t              rx_state;
    logic [DATA_WIDTH-1:0]  rx_shift;
    logic [RX_CW-1:0]       rx_cnt;
    logic                   rx_push;

    logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [AW:0]            wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   tx_pop;

    tx_state_t              tx_state;
    logic [DATA_WIDTH-1:0]  tx_shift;
    logic [TX_CW-1:0]       tx_bit;
    logic [DIV_W-1:0]       div_cnt;

    // Bus lines idle high, so the synchronizer resets high to avoid a phantom edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            {scl_meta, scl_s, scl_d} <= 3'b111;
            {sda_meta, sda_s, sda_d} <= 3'b111;
        end else begin
            scl_meta <= i2c_scl;
            scl_s    <= scl_meta;
            scl_d    <= scl_s;
            sda_meta <= i2c_sda;
            sda_s    <= sda_meta;
            sda_d    <= sda_s;
        end
    end

    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign rx_push = (rx_state == R_DATA) && scl_fall && (rx_cnt == RX_FULL_CNT) && !fifo_full;
    assign tx_pop  = (tx_state == S_IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state   <= R_IDLE;
            rx_shift   <= '0;
            rx_cnt     <= '0;
            i2c_sda_oe <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (stop_det) begin
                rx_state   <= R_IDLE;
                rx_cnt     <= '0;
                i2c_sda_oe <= 1'b0;
            end else if (start_det) begin
                rx_state   <= R_DATA;
                rx_cnt     <= '0;
                i2c_sda_oe <= 1'b0;
            end else begin
                case (rx_state)
                    R_IDLE: ;
                    R_DATA: begin
                        if (scl_rise && rx_cnt != RX_FULL_CNT) begin
                            rx_shift <= {rx_shift[DATA_WIDTH-2:0], sda_s};
                            rx_cnt   <= rx_cnt + 1'b1;
                        end else if (scl_fall && rx_cnt == RX_FULL_CNT) begin
                            // A full FIFO turns the ACK slot into a NACK plus an overflow pulse.
                            i2c_sda_oe <= !fifo_full;
                            overflow   <= fifo_full;
                            rx_state   <= R_ACK;
                        end
                    end
                    R_ACK: begin
                        if (scl_fall) begin
                            i2c_sda_oe <= 1'b0;
                            rx_cnt     <= '0;
                            rx_state   <= R_DATA;
                        end
                    end
                    default: rx_state <= R_IDLE;
                endcase
            end
        end
    end

    // Storage is not reset; only the pointers define what the FIFO holds.
    always_ff @(posedge clk) begin
        if (rx_push)
            mem[wr_ptr[AW-1:0]] <= rx_shift;
        if (tx_pop)
            rd_data <= mem[rd_ptr[AW-1:0]];
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rx_push)
                wr_ptr <= wr_ptr + (AW+1)'(1);
            if (tx_pop)
                rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    assign spi_mosi = tx_shift[DATA_WIDTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_shift <= '0;
            tx_bit   <= '0;
            div_cnt  <= '0;
            spi_sclk <= 1'b0;
            spi_cs_n <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: begin
                    if (!fifo_empty)
                        tx_state <= S_LOAD;
                end
                S_LOAD: begin
                    tx_shift <= rd_data;
                    tx_bit   <= '0;
                    div_cnt  <= '0;
                    spi_sclk <= 1'b0;
                    spi_cs_n <= 1'b0;
                    tx_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                        end else begin
                            // MOSI advances only on the high-to-low SCLK transition.
                            spi_sclk <= 1'b0;
                            if (tx_bit == TX_LAST_BIT) begin
                                spi_cs_n <= 1'b1;
                                tx_state <= S_GAP;
                            end else begin
                                tx_bit   <= tx_bit + 1'b1;
                                tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt  <= '0;
                        tx_state <= S_IDLE;
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_to_spi_fifo.sv
// tb_i2c_to_spi_fifo: drives I2C byte traffic (directed and $urandom) and checks ACKs,
// overflow and the SPI byte stream against a queue-based occupancy model.
`timescale 1ns/1ps
module tb_i2c_to_spi_fifo;
    localparam int DW        = 8;
    localparam int DEPTH     = 8;
    // Slow SPI drain so a fast I2C burst can fill the FIFO.
    localparam int DIV       = 64;
    localparam int FRAME_LOW = 2 * DIV * DW;
    localparam int MIN_GAP   = DIV + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i2c_scl = 1'b1;
    logic i2c_sda = 1'b1;
    logic i2c_sda_oe, spi_sclk, spi_mosi, spi_cs_n, fifo_full, fifo_empty, overflow;

    int checks = 0;
    int passes = 0;
    int half = 6;
    int accepted = 0;

    logic [7:0] exp_q[$];
    logic [7:0] stim_q[$];

    int frames_started = 0;
    int ovf_pulses = 0;
    int ovf_high_cycles = 0;
    int mosi_glitches = 0;
    int sclk_idle_errs = 0;

    logic          prev_cs = 1'b1, prev_sclk = 1'b0, prev_mosi = 1'b0, prev_ovf = 1'b0;
    logic          in_frame = 1'b0, have_gap = 1'b0;
    int            low_cnt = 0, gap_cnt = 0, bits = 0;
    logic [DW-1:0] shreg = '0;

    i2c_to_spi_fifo #(
        .DATA_WIDTH (DW),
        .FIFO_DEPTH (DEPTH),
        .SPI_CLK_DIV(DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i2c_scl   (i2c_scl),
        .i2c_sda   (i2c_sda),
        .i2c_sda_oe(i2c_sda_oe),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_cs_n  (spi_cs_n),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #(95000 * 10);
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed == expected)
            passes++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    endtask

    // SPI monitor: rebuilds each frame from MOSI on SCLK rises and scores it in order.
    always @(negedge clk) begin
        if (overflow) begin
            ovf_high_cycles++;
            if (!prev_ovf)
                ovf_pulses++;
        end
        prev_ovf = overflow;
        if (rst) begin
            in_frame = 1'b0;
            have_gap = 1'b0;
            gap_cnt = 0;
            frames_started = 0;
            exp_q.delete();
            prev_cs = 1'b1;
            prev_sclk = 1'b0;
            prev_mosi = spi_mosi;
        end else begin
            if (!prev_cs && spi_cs_n && in_frame) begin
                checkOutput("cs_low_cycles", low_cnt, FRAME_LOW);
                checkOutput("frame_bits", bits, DW);
                checkOutput("spi_frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    checkOutput("spi_byte", shreg, exp_q.pop_front());
                in_frame = 1'b0;
                have_gap = 1'b1;
                gap_cnt = 0;
            end
            if (prev_cs && !spi_cs_n) begin
                if (have_gap)
                    checkOutput("cs_gap_ok", gap_cnt >= MIN_GAP, 1);
                in_frame = 1'b1;
                low_cnt = 0;
                bits = 0;
                shreg = '0;
                frames_started++;
            end
            if (!spi_cs_n) begin
                low_cnt++;
                if (!prev_sclk && spi_sclk) begin
                    if (bits == 0)
                        checkOutput("first_sclk_rise", low_cnt, DIV + 1);
                    shreg = {shreg[DW-2:0], spi_mosi};
                    bits++;
                end
                if (!prev_cs && spi_mosi != prev_mosi && !(prev_sclk && !spi_sclk))
                    mosi_glitches++;
            end else begin
                gap_cnt++;
                if (spi_sclk)
                    sclk_idle_errs++;
            end
            prev_cs = spi_cs_n;
            prev_sclk = spi_sclk;
            prev_mosi = spi_mosi;
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2cStart();
        if (!i2c_scl) begin
            @(negedge clk);
            i2c_sda = 1'b1;
            waitCycles(half);
            i2c_scl = 1'b1;
            waitCycles(half);
        end
        i2c_sda = 1'b0;
        waitCycles(half);
        i2c_scl = 1'b0;
    endtask

    task automatic i2cStop();
        @(negedge clk);
        i2c_sda = 1'b0;
        waitCycles(half - 1);
        i2c_scl = 1'b1;
        waitCycles(half);
        i2c_sda = 1'b1;
        waitCycles(half);
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        i2c_sda = b;
        waitCycles(half - 1);
        i2c_scl = 1'b1;
        waitCycles(half);
        i2c_scl = 1'b0;
    endtask

    task automatic sendBits(input logic [7:0] data, input int n);
        for (int i = 0; i < n; i++)
            sendBit(data[7-i]);
    endtask

    // One data byte plus its ACK slot; the model decides ACK from its own occupancy.
    task automatic sendByte(input logic [7:0] data);
        logic exp_ack;
        int   ovf_before;
        ovf_before = ovf_pulses;
        sendBits(data, 8);
        exp_ack = ((accepted - frames_started) < DEPTH);
        @(negedge clk);
        i2c_sda = 1'b1;
        @(negedge clk);
        checkOutput("ack_early", i2c_sda_oe, 0);
        @(negedge clk);
        checkOutput("ack_assert", i2c_sda_oe, exp_ack);
        if (exp_ack) begin
            exp_q.push_back(data);
            accepted++;
        end
        waitCycles(half - 3);
        i2c_scl = 1'b1;
        waitCycles(half / 2);
        checkOutput("ack_hold", i2c_sda_oe, exp_ack);
        waitCycles(half - half / 2);
        i2c_scl = 1'b0;
        waitCycles(2);
        checkOutput("ack_keep", i2c_sda_oe, exp_ack);
        @(negedge clk);
        checkOutput("ack_release", i2c_sda_oe, 0);
        checkOutput("overflow_pulse", ovf_pulses - ovf_before, exp_ack ? 0 : 1);
        checkOutput("fifo_full", fifo_full, (accepted - frames_started) == DEPTH);
    endtask

    task automatic applyStimulus();
        i2cStart();
        foreach (stim_q[i])
            sendByte(stim_q[i]);
        i2cStop();
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((exp_q.size() != 0 || !spi_cs_n) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_done", exp_q.size(), 0);
        waitCycles(2 * DIV);
        checkOutput("fifo_empty_idle", fifo_empty, 1);
    endtask

    initial begin
        int n;
        int nb;
        waitCycles(5);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_sda_oe", i2c_sda_oe, 0);
        checkOutput("rst_sclk", spi_sclk, 0);
        checkOutput("rst_mosi", spi_mosi, 0);
        checkOutput("rst_cs_n", spi_cs_n, 1);
        checkOutput("rst_empty", fifo_empty, 1);
        checkOutput("rst_full", fifo_full, 0);
        checkOutput("rst_overflow", overflow, 0);
        waitCycles(10);

        $display("[TB] single byte");
        half = 6;
        stim_q = '{8'hA5};
        applyStimulus();
        waitDrain();

        $display("[TB] burst");
        stim_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        applyStimulus();
        waitDrain();

        $display("[TB] overflow burst");
        half = 5;
        stim_q.delete();
        for (int k = 0; k < 10; k++)
            stim_q.push_back(8'($urandom));
        applyStimulus();
        checkOutput("overflow_total", ovf_pulses, 1);
        waitDrain();

        $display("[TB] aborted byte");
        half = 6;
        i2cStart();
        sendBits(8'hFF, 5);
        i2cStop();
        stim_q = '{8'h3C};
        applyStimulus();
        waitDrain();

        $display("[TB] repeated start");
        i2cStart();
        sendBits(8'($urandom), 3);
        i2cStart();
        sendByte(8'h81);
        i2cStop();
        waitDrain();

        $display("[TB] random rounds");
        for (int r = 0; r < 6; r++) begin
            half = $urandom_range(8, 5);
            stim_q.delete();
            nb = $urandom_range(3, 1);
            for (int k = 0; k < nb; k++)
                stim_q.push_back(8'($urandom));
            if ($urandom_range(2, 0) == 0) begin
                i2cStart();
                sendBits(8'($urandom), $urandom_range(7, 1));
                i2cStop();
            end
            applyStimulus();
            waitDrain();
        end

        $display("[TB] reset mid-frame");
        half = 6;
        stim_q = '{8'h5A, 8'hC3};
        applyStimulus();
        n = 0;
        while (spi_cs_n && n < 5000) begin
            @(negedge clk);
            n++;
        end
        waitCycles(3 * DIV);
        checkOutput("pre_reset_cs_low", spi_cs_n, 0);
        checkOutput("pre_reset_not_empty", fifo_empty, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("mid_rst_cs_n", spi_cs_n, 1);
        checkOutput("mid_rst_sclk", spi_sclk, 0);
        checkOutput("mid_rst_empty", fifo_empty, 1);
        checkOutput("mid_rst_sda_oe", i2c_sda_oe, 0);
        @(negedge clk);
        rst = 1'b0;
        accepted = 0;
        waitCycles(4 * DIV);
        checkOutput("post_rst_cs_idle", spi_cs_n, 1);
        checkOutput("post_rst_frames", frames_started, 0);

        checkOutput("overflow_one_cycle", ovf_high_cycles, ovf_pulses);
        checkOutput("mosi_stable", mosi_glitches, 0);
        checkOutput("sclk_idle_low", sclk_idle_errs, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
